sequence_generator: RTL and testbench
=====================================

Name: sequence_generator

Overview:
Serial pattern transmitter: the source end of the single-bit serial stream consumed by our sequence detector.
- Accepts a parallel word over a valid/ready handshake.
- Shifts the word out MSB-first, one bit per clk, repeating it a programmable number of times back-to-back.
- Drives the detector's x input, both in the datapath and in its self-test bench.

Parameters:
WIDTH, 5, bits per word; legal range 2..32.
RPT_W, 4, width of the repeat-count field.
IDLE_BIT, 1, level driven on x when not transmitting. The default 1 keeps the detector parked in its reset state.

Ports:
clk  input  1  rising-edge clock, single clock domain
reset_n  input  1  asynchronous, active-low reset
din  input  WIDTH  word to transmit, MSB sent first
rpt  input  RPT_W  extra repetitions; the word is sent rpt+1 times
din_valid  input  1  request; din and rpt are valid
din_ready  output  1  block can accept a word
x  output  1  serial data out
x_valid  output  1  x carries a payload bit this cycle
busy  output  1  transmission in progress
done  output  1  one-cycle pulse after the last bit of the last repetition

Behaviour:
- All outputs are registered.
- Reset values (while reset_n=0, asynchronous): state=IDLE, x=IDLE_BIT, x_valid=0, busy=0, done=0, din_ready=1, all counters 0, shift register 0.
- Reset asserted mid-transmission aborts immediately. No done pulse; the partial word is discarded.
- States:
  - IDLE: din_ready=1, x=IDLE_BIT, x_valid=0, busy=0.
  - SHIFT: din_ready=0, busy=1, x_valid=1.
  - DONE: one cycle; done=1, x=IDLE_BIT, x_valid=0, busy=0, din_ready=0.
- Handshake:
  - A transfer occurs at a rising edge where din_valid=1 and din_ready=1.
  - On transfer, din is captured into both shift register and word register, rpt into rep_cnt, bit_cnt is cleared, and the state moves to SHIFT.
  - din_valid while din_ready=0 is ignored; nothing is queued.
  - din and rpt need only be stable in the transfer cycle.
- Latency: transfer at edge k puts the first bit (din[WIDTH-1]) on x with x_valid=1 in the cycle after edge k.
- SHIFT operation:
  - Each edge shifts left, so x = shreg[WIDTH-1]; bit_cnt increments.
  - After the bit with bit_cnt=WIDTH-1, if rep_cnt!=0: reload shreg from the word register, decrement rep_cnt, clear bit_cnt, stay in SHIFT.
  - There is no idle gap between repetitions: consecutive words form one continuous stream, so patterns overlapping a word boundary are visible to the detector.
  - After the last bit with rep_cnt=0: go to DONE.
- DONE to IDLE takes exactly one cycle. The earliest next transfer is at the edge ending the first IDLE cycle.
- Total bits per job = WIDTH*(rpt+1).
- rep_cnt never wraps: it is checked for 0 before decrementing.
- rpt at its maximum (2^RPT_W-1) gives WIDTH*2^RPT_W bits.
- x_valid is high for exactly WIDTH*(rpt+1) consecutive cycles per job.

Test Plan:
1. Reset, then din=5'b01101, rpt=0, one-cycle transfer.
   - Required: x=0,1,1,0,1 with x_valid=1 in cycles 1..5; done=1 in cycle 6; din_ready=1 again in cycle 7.
   - Chained to the detector, z=1 in cycle 5 only.
2. din=5'b01101, rpt=2.
   - Required: 15 contiguous valid bits 011010110101101; exactly one done pulse, in cycle 16.
   - Detector z=1 at bits 5, 10 and 15.
3. din=5'b11111 with din_valid held high continuously.
   - Required: second transfer only after DONE plus one IDLE cycle. x=IDLE_BIT (1) and x_valid=0 between jobs; no bit is lost or duplicated.
4. Assert reset_n=0 asynchronously mid-word, at the 3rd bit of din=5'b10010.
   - Required: x=1, x_valid=0, busy=0, din_ready=1 immediately, before the next clk edge. No done pulse.
5. rpt=4'hF, din=5'b10000.
   - Required: 80 valid bits; a 1 every 5th bit starting at bit 1; done after bit 80; rep_cnt does not underflow.
6. WIDTH=8, IDLE_BIT=0, din=8'hA5, rpt=0.
   - Required: x=1,0,1,0,0,1,0,1; x=0 while idle.

Source files
------------

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: accepts a parallel word over valid/ready and
// streams it MSB-first on x, repeating it rpt+1 times back-to-back.
module sequence_generator #(
  parameter int   WIDTH    = 5,
  parameter int   RPT_W    = 4,
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic [RPT_W-1:0] rpt,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic [RPT_W-1:0]   rep_cnt_q, rep_cnt_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               x_q, x_d;
  logic               x_valid_q, x_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               din_ready_q, din_ready_d;

  // Next-state and next-output logic for the transmit FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    shreg_d     = shreg_q;
    word_d      = word_q;
    rep_cnt_d   = rep_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    x_d         = x_q;
    x_valid_d   = x_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    din_ready_d = din_ready_q;

    unique case (state_q)
      ST_IDLE: begin
        x_d       = IDLE_BIT;
        x_valid_d = 1'b0;
        busy_d    = 1'b0;
        if (din_valid && din_ready_q) begin
          state_d     = ST_SHIFT;
          shreg_d     = din;
          word_d      = din;
          rep_cnt_d   = rpt;
          bit_cnt_d   = '0;
          x_d         = din[WIDTH-1];
          x_valid_d   = 1'b1;
          busy_d      = 1'b1;
          din_ready_d = 1'b0;
        end
      end

      ST_SHIFT: begin
        if (bit_cnt_q != LAST_BIT) begin
          // Rotate left: the bit now leaving on x wraps into the LSB, so
          // shreg_q[WIDTH-1] always mirrors the bit currently on x.
          shreg_d   = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          x_d       = shreg_q[WIDTH-2];
        end else if (rep_cnt_q != '0) begin
          // Reload without a gap so repetitions form one continuous stream.
          shreg_d   = word_q;
          rep_cnt_d = rep_cnt_q - RPT_W'(1);
          bit_cnt_d = '0;
          x_d       = word_q[WIDTH-1];
        end else begin
          state_d   = ST_DONE;
          bit_cnt_d = '0;
          x_d       = IDLE_BIT;
          x_valid_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end
      end

      ST_DONE: begin
        state_d     = ST_IDLE;
        din_ready_d = 1'b1;
      end

      default: begin
        state_d     = ST_IDLE;
        x_d         = IDLE_BIT;
        x_valid_d   = 1'b0;
        busy_d      = 1'b0;
        din_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset aborts any job in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      word_q      <= '0;
      rep_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      x_q         <= IDLE_BIT;
      x_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      din_ready_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      word_q      <= word_d;
      rep_cnt_q   <= rep_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      x_q         <= x_d;
      x_valid_q   <= x_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      din_ready_q <= din_ready_d;
    end
  end

  assign x         = x_q;
  assign x_valid   = x_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign din_ready = din_ready_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench: two configurations (5-bit idle-high, 8-bit idle-low)
// compared cycle by cycle against a word-repetition model of the stream.
module tb_sequence_generator;

  localparam int W_A = 5;
  localparam int W_B = 8;

  logic           clk = 1'b0;
  logic           reset_n;

  logic [W_A-1:0] din_a;
  logic [3:0]     rpt_a;
  logic           vld_a, rdy_a, x_a, xv_a, busy_a, done_a;

  logic [W_B-1:0] din_b;
  logic [3:0]     rpt_b;
  logic           vld_b, rdy_b, x_b, xv_b, busy_b, done_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sequence_generator #(.WIDTH(W_A), .RPT_W(4), .IDLE_BIT(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .din(din_a), .rpt(rpt_a),
    .din_valid(vld_a), .din_ready(rdy_a), .x(x_a), .x_valid(xv_a),
    .busy(busy_a), .done(done_a)
  );

  sequence_generator #(.WIDTH(W_B), .RPT_W(4), .IDLE_BIT(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .din(din_b), .rpt(rpt_b),
    .din_valid(vld_b), .din_ready(rdy_b), .x(x_b), .x_valid(xv_b),
    .busy(busy_b), .done(done_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compares {x, x_valid, busy, done, din_ready} of the selected instance.
  task automatic check_cycle(input int sel, input string tag,
                             input logic ex, input logic exv, input logic ebusy,
                             input logic edone, input logic erdy);
    logic [4:0] got;
    got = (sel == 0) ? {x_a, xv_a, busy_a, done_a, rdy_a}
                     : {x_b, xv_b, busy_b, done_b, rdy_b};
    check(tag, {27'd0, got}, {27'd0, ex, exv, ebusy, edone, erdy});
  endtask

  task automatic drive(input int sel, input logic [31:0] word, input int rpt, input logic v);
    if (sel == 0) begin
      din_a = word[W_A-1:0];
      rpt_a = rpt[3:0];
      vld_a = v;
    end else begin
      din_b = word[W_B-1:0];
      rpt_b = rpt[3:0];
      vld_b = v;
    end
  endtask

  // Called at a negedge of an IDLE cycle; returns at the negedge of the
  // first IDLE cycle after the job, the earliest point a new job may start.
  task automatic run_job(input int sel, input logic [31:0] word, input int rpt,
                         input bit hold, input string tag);
    int   w;
    int   n;
    logic idle;
    logic eb;
    w    = (sel == 0) ? W_A : W_B;
    idle = (sel == 0) ? 1'b1 : 1'b0;
    n    = w * (rpt + 1);
    drive(sel, word, rpt, 1'b1);
    check_cycle(sel, {tag, "_pre"}, idle, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    // After the transfer the inputs are scrambled; when hold is set the
    // request stays asserted and must be ignored until the block is idle.
    drive(sel, $urandom, $urandom_range(0, 15), hold ? 1'b1 : 1'b0);
    for (int i = 0; i < n; i++) begin
      eb = word[w - 1 - (i % w)];
      check_cycle(sel, $sformatf("%s_bit%0d", tag, i + 1), eb, 1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
    end
    check_cycle(sel, {tag, "_done"}, idle, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check_cycle(sel, {tag, "_idle"}, idle, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    reset_n = 1'b1;
    drive(0, 0, 0, 1'b0);
    drive(1, 0, 0, 1'b0);
    #1 reset_n = 1'b0;
    #2;
    check_cycle(0, "rst_a", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_cycle(1, "rst_b", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check_cycle(0, "post_rst_a", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Single word, no repeat.
    run_job(0, 32'b01101, 0, 1'b0, "t1");
    // Three back-to-back repetitions.
    run_job(0, 32'b01101, 2, 1'b0, "t2");
    // Request held high across the whole job, then a second job.
    run_job(0, 32'b11111, 0, 1'b1, "t3a");
    run_job(0, 32'b11111, 1, 1'b0, "t3b");
    // Maximum repeat count.
    run_job(0, 32'b10000, 15, 1'b0, "t5");
    // Wide word with idle-low line.
    run_job(1, 32'hA5, 0, 1'b0, "t6");

    // Asynchronous reset in the middle of the third bit.
    drive(0, 32'b10010, 0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    check_cycle(0, "t4_bit3", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1 check_cycle(0, "t4_async", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_cycle(0, $sformatf("t4_after%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
    end

    // Randomized jobs: first half on the 5-bit instance, second on the 8-bit.
    for (int k = 0; k < 12; k++) begin
      int sel;
      bit hold;
      sel  = k / 6;
      hold = (k == 5 || k == 11) ? 1'b0 : 1'($urandom_range(0, 1));
      run_job(sel, $urandom, ((k % 4) == 3) ? 15 : $urandom_range(0, 3), hold,
              $sformatf("rnd%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
